// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control pipeline for the 5-stage MIPS core.
// Also produces load-use stall, taken-BEQ flush and EX forwarding selects.
module ctrl_pipeline #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_MemToReg,
  input  logic             id_ALUSrc,
  input  logic [1:0]       id_ALUOp,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_wreg,
  input  logic             ex_zero,
  output logic             stall,
  output logic             flush,
  output logic             ex_valid,
  output logic             ex_ALUSrc,
  output logic [1:0]       ex_ALUOp,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             mem_valid,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic             wb_valid,
  output logic             wb_RegWrite,
  output logic             wb_MemToReg,
  output logic [REG_W-1:0] wb_wreg
);

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             alu_src;
    logic [1:0]       alu_op;
    logic [REG_W-1:0] wreg;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } ex_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] wreg;
  } mem_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem_to_reg;
    logic [REG_W-1:0] wreg;
  } wb_t;

  ex_t  ex_q, ex_d;
  mem_t mem_q, mem_d;
  wb_t  wb_q, wb_d;

  logic uses_rt;
  logic load_hit;
  logic mem_fw, wb_fw;

  assign flush = ex_q.valid & (ex_q.alu_op == 2'b01) & ex_zero;

  assign uses_rt  = ~id_ALUSrc | id_MemWrite;
  assign load_hit = ex_q.valid & ex_q.mem_read
                  & (ex_q.wreg != '0) & id_valid
                  & ((ex_q.wreg == id_rs)
                   | (uses_rt & (ex_q.wreg == id_rt)));
  assign stall    = load_hit & ~flush;

  // Squashed, stalled and invalid slots all become all-zero bubbles
  always_comb begin
    ex_d = '0;
    if (id_valid && !flush && !stall) begin
      ex_d.valid      = 1'b1;
      ex_d.reg_write  = id_RegWrite;
      ex_d.mem_read   = id_MemRead;
      ex_d.mem_write  = id_MemWrite;
      ex_d.mem_to_reg = id_MemToReg;
      ex_d.alu_src    = id_ALUSrc;
      ex_d.alu_op     = id_ALUOp;
      ex_d.wreg       = id_wreg;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
    end
  end

  always_comb begin
    mem_d            = '0;
    mem_d.valid      = ex_q.valid;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.wreg       = ex_q.wreg;
  end

  always_comb begin
    wb_d            = '0;
    wb_d.valid      = mem_q.valid;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.wreg       = mem_q.wreg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign mem_fw = mem_q.valid & mem_q.reg_write
                & (mem_q.wreg != '0);
  assign wb_fw  = wb_q.valid & wb_q.reg_write
                & (wb_q.wreg != '0);

  // MEM result is younger, so it wins over WB
  always_comb begin
    forwardA = 2'b00;
    if (ex_q.valid) begin
      if (mem_fw && mem_q.wreg == ex_q.rs)
        forwardA = 2'b10;
      else if (wb_fw && wb_q.wreg == ex_q.rs)
        forwardA = 2'b01;
    end
  end

  always_comb begin
    forwardB = 2'b00;
    if (ex_q.valid) begin
      if (mem_fw && mem_q.wreg == ex_q.rt)
        forwardB = 2'b10;
      else if (wb_fw && wb_q.wreg == ex_q.rt)
        forwardB = 2'b01;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_ALUOp     = ex_q.alu_op;
  assign mem_valid    = mem_q.valid;
  assign mem_MemRead  = mem_q.valid & mem_q.mem_read;
  assign mem_MemWrite = mem_q.valid & mem_q.mem_write;
  assign wb_valid     = wb_q.valid;
  assign wb_RegWrite  = wb_q.valid & wb_q.reg_write;
  assign wb_MemToReg  = wb_q.mem_to_reg;
  assign wb_wreg      = wb_q.wreg;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Scoreboard bench for ctrl_pipeline: directed hazard cases plus
// random instruction streams checked against an instruction-level model.
module tb_ctrl_pipeline;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       m2r;
    logic       as;
    logic [1:0] op;
    logic [4:0] wreg;
    logic [4:0] rs;
    logic [4:0] rt;
  } ins_t;

  typedef struct packed {
    ins_t i;
    logic z;
  } stim_t;

  typedef struct packed {
    logic       st;
    logic       fl;
    logic       exv;
    logic       exas;
    logic [1:0] exop;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       memv;
    logic       memmr;
    logic       memmw;
    logic       wbv;
    logic       wbrw;
    logic       wbm2r;
    logic [4:0] wbwr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ins_t id_cur = '0;
  logic zero_cur = 1'b0;

  logic       stall, flush, ex_valid, ex_ALUSrc;
  logic [1:0] ex_ALUOp, forwardA, forwardB;
  logic       mem_valid, mem_MemRead, mem_MemWrite;
  logic       wb_valid, wb_RegWrite, wb_MemToReg;
  logic [4:0] wb_wreg;

  ctrl_pipeline #(.REG_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_cur.v),
    .id_RegWrite  (id_cur.rw),
    .id_MemRead   (id_cur.mr),
    .id_MemWrite  (id_cur.mw),
    .id_MemToReg  (id_cur.m2r),
    .id_ALUSrc    (id_cur.as),
    .id_ALUOp     (id_cur.op),
    .id_rs        (id_cur.rs),
    .id_rt        (id_cur.rt),
    .id_wreg      (id_cur.wreg),
    .ex_zero      (zero_cur),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_ALUSrc    (ex_ALUSrc),
    .ex_ALUOp     (ex_ALUOp),
    .forwardA     (forwardA),
    .forwardB     (forwardB),
    .mem_valid    (mem_valid),
    .mem_MemRead  (mem_MemRead),
    .mem_MemWrite (mem_MemWrite),
    .wb_valid     (wb_valid),
    .wb_RegWrite  (wb_RegWrite),
    .wb_MemToReg  (wb_MemToReg),
    .wb_wreg      (wb_wreg)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: the three in-flight instructions
  ins_t m_ex = '0, m_mem = '0, m_wb = '0;
  stim_t stim_q[$];
  exp_t  exp_q[$];

  function automatic logic m_flush();
    return m_ex.v && m_ex.op == 2'b01 && zero_cur;
  endfunction

  function automatic logic m_stall();
    logic rd_rt;
    logic hit;
    rd_rt = !id_cur.as || id_cur.mw;
    hit = (m_ex.wreg == id_cur.rs)
       || (rd_rt && m_ex.wreg == id_cur.rt);
    return m_ex.v && m_ex.mr && m_ex.wreg != 0
        && id_cur.v && hit && !m_flush();
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] r);
    if (!m_ex.v || r == 0) return 2'b00;
    if (m_mem.v && m_mem.rw && m_mem.wreg == r) return 2'b10;
    if (m_wb.v && m_wb.rw && m_wb.wreg == r) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t m_expect();
    exp_t e;
    e.st    = m_stall();
    e.fl    = m_flush();
    e.exv   = m_ex.v;
    e.exas  = m_ex.as;
    e.exop  = m_ex.op;
    e.fa    = m_fwd(m_ex.rs);
    e.fb    = m_fwd(m_ex.rt);
    e.memv  = m_mem.v;
    e.memmr = m_mem.v & m_mem.mr;
    e.memmw = m_mem.v & m_mem.mw;
    e.wbv   = m_wb.v;
    e.wbrw  = m_wb.v & m_wb.rw;
    e.wbm2r = m_wb.m2r;
    e.wbwr  = m_wb.wreg;
    return e;
  endfunction

  // One clock: advance the model, present next ID, log expectation
  task automatic step();
    logic st, fl;
    stim_t s;
    @(posedge clk);
    st = m_stall();
    fl = m_flush();
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ex  = (st || fl || !id_cur.v) ? '0 : id_cur;
    #1;
    if (!st) begin
      s = '0;
      if (stim_q.size() > 0) s = stim_q.pop_front();
      id_cur   = s.i;
      zero_cur = s.z;
    end
    exp_q.push_back(m_expect());
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",    int'(stall),        int'(e.st));
      chk("flush",    int'(flush),        int'(e.fl));
      chk("ex_valid", int'(ex_valid),     int'(e.exv));
      chk("ex_ALUSrc", int'(ex_ALUSrc),   int'(e.exas));
      chk("ex_ALUOp", int'(ex_ALUOp),     int'(e.exop));
      chk("forwardA", int'(forwardA),     int'(e.fa));
      chk("forwardB", int'(forwardB),     int'(e.fb));
      chk("mem_valid", int'(mem_valid),   int'(e.memv));
      chk("mem_MemRead", int'(mem_MemRead), int'(e.memmr));
      chk("mem_MemWrite", int'(mem_MemWrite), int'(e.memmw));
      chk("wb_valid", int'(wb_valid),     int'(e.wbv));
      chk("wb_RegWrite", int'(wb_RegWrite), int'(e.wbrw));
      chk("wb_MemToReg", int'(wb_MemToReg), int'(e.wbm2r));
      chk("wb_wreg",  int'(wb_wreg),      int'(e.wbwr));
    end
  end

  function automatic ins_t rtype(input int d, input int s,
                                 input int t);
    ins_t i = '0;
    i.v = 1; i.rw = 1; i.op = 2'b10;
    i.wreg = 5'(d); i.rs = 5'(s); i.rt = 5'(t);
    return i;
  endfunction

  function automatic ins_t lw(input int d, input int b);
    ins_t i = '0;
    i.v = 1; i.rw = 1; i.mr = 1; i.m2r = 1; i.as = 1;
    i.wreg = 5'(d); i.rs = 5'(b); i.rt = 5'(d);
    return i;
  endfunction

  function automatic ins_t sw(input int b, input int t);
    ins_t i = '0;
    i.v = 1; i.mw = 1; i.as = 1;
    i.rs = 5'(b); i.rt = 5'(t);
    return i;
  endfunction

  function automatic ins_t addi(input int t, input int s);
    ins_t i = '0;
    i.v = 1; i.rw = 1; i.as = 1;
    i.wreg = 5'(t); i.rs = 5'(s); i.rt = 5'(t);
    return i;
  endfunction

  function automatic ins_t beq(input int s, input int t);
    ins_t i = '0;
    i.v = 1; i.op = 2'b01;
    i.rs = 5'(s); i.rt = 5'(t);
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    int a, b, c;
    a = $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    case ($urandom_range(0, 4))
      0: i = lw(a, b);
      1: i = sw(a, b);
      2: i = addi(a, b);
      3: i = beq(a, b);
      default: i = rtype(a, b, c);
    endcase
    if ($urandom_range(0, 7) == 0) i.v = 0;
    return i;
  endfunction

  task automatic pu(input ins_t i, input logic z);
    stim_t s;
    s.i = i;
    s.z = z;
    stim_q.push_back(s);
  endtask

  task automatic nops(input int n);
    for (int k = 0; k < n; k++) pu('0, 1'b0);
  endtask

  task automatic run_all();
    int guard = 0;
    while (stim_q.size() > 0 && guard < 20000) begin
      step();
      guard++;
    end
    chk("stim_drained", stim_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, int'(stall), 0);
    chk({tag, "_flush"}, int'(flush), 0);
    chk({tag, "_ex_valid"}, int'(ex_valid), 0);
    chk({tag, "_fwd"}, int'({forwardA, forwardB}), 0);
    chk({tag, "_mem_valid"}, int'(mem_valid), 0);
    chk({tag, "_mem_ctl"}, int'({mem_MemRead, mem_MemWrite}), 0);
    chk({tag, "_wb_valid"}, int'(wb_valid), 0);
    chk({tag, "_wb_ctl"}, int'({wb_RegWrite, wb_MemToReg}), 0);
    chk({tag, "_wb_wreg"}, int'(wb_wreg), 0);
  endtask

  initial begin
    ins_t odd;
    #2;
    chk_zero("por");
    #10 reset = 1'b0;

    // Back-to-back and one-apart forwarding
    pu(rtype(3, 1, 2), 0); pu(rtype(4, 3, 1), 0); nops(3);
    pu(rtype(3, 1, 2), 0); pu(rtype(6, 1, 2), 0);
    pu(rtype(4, 3, 1), 0); nops(3);
    // Load-use via rt, SW data, addi not using rt
    pu(lw(5, 1), 0); pu(rtype(7, 1, 5), 0); nops(3);
    pu(lw(5, 1), 0); pu(sw(2, 5), 0); nops(3);
    pu(lw(5, 1), 0); pu(addi(5, 1), 0); nops(3);
    // Taken and not-taken BEQ
    pu(beq(1, 2), 0); pu(rtype(3, 1, 2), 1);
    pu(rtype(4, 1, 2), 0); nops(3);
    pu(beq(1, 2), 0); pu(rtype(3, 1, 2), 0);
    pu(rtype(4, 3, 2), 0); nops(3);
    // Flush outranks a simultaneous load-use match
    odd = beq(1, 2);
    odd.mr = 1; odd.wreg = 5;
    pu(odd, 0); pu(rtype(6, 5, 5), 1); nops(3);
    // $zero never stalls or forwards
    pu(lw(0, 1), 0); pu(rtype(2, 0, 0), 0); nops(3);
    pu(rtype(0, 1, 2), 0); pu(rtype(3, 4, 4), 0);
    pu(rtype(7, 0, 0), 0); nops(3);
    run_all();

    for (int n = 0; n < 400; n++) pu(rnd_ins(), 1'($urandom_range(0, 1)));
    nops(3);
    run_all();

    // Asynchronous reset with three R-types in flight
    pu(rtype(1, 2, 3), 0); pu(rtype(2, 1, 3), 0);
    pu(rtype(3, 2, 1), 0);
    run_all();
    step();
    @(negedge clk);
    #1;
    chk("inflight_ex", int'(ex_valid), 1);
    chk("inflight_wb", int'(wb_valid), 1);
    reset = 1'b1;
    #1;
    chk_zero("async_rst");
    m_ex = '0; m_mem = '0; m_wb = '0;
    id_cur = '0; zero_cur = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;

    pu(lw(2, 1), 0); pu(rtype(3, 2, 2), 0); nops(4);
    run_all();
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
Carries the decoded control bundle (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp) from the ID stage through the EX, MEM and WB pipeline registers of the 5-stage MIPS core.
It is the consumer side of the opcode decoder. It also detects load-use hazards (stall), resolves taken BEQ in EX (flush) and generates EX-stage operand forwarding selects.
The IF/ID register and PC hold/squash logic are upstream and are driven by the stall and flush outputs.

Parameters:
REG_W, 5, register-specifier width (32 architectural registers).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_RegWrite  in  1  decoded control from ID
id_MemRead  in  1  decoded control from ID
id_MemWrite  in  1  decoded control from ID
id_MemToReg  in  1  decoded control from ID
id_ALUSrc  in  1  decoded control from ID
id_ALUOp  in  2  decoded control from ID (00 mem, 01 BEQ, 10 R-type)
id_rs  in  REG_W  source register 1
id_rt  in  REG_W  source register 2
id_wreg  in  REG_W  destination register (rd or rt, already selected upstream)
ex_zero  in  1  ALU zero flag of the instruction currently in EX
stall  out  1  load-use hazard: upstream holds PC and IF/ID
flush  out  1  taken branch in EX: upstream squashes IF/ID and redirects PC
ex_valid  out  1  EX-stage valid
ex_ALUSrc  out  1  EX-stage control
ex_ALUOp  out  2  EX-stage control
forwardA  out  2  ALU operand A select (00 regfile, 10 from MEM, 01 from WB)
forwardB  out  2  ALU operand B select, same encoding
mem_valid  out  1  MEM-stage valid
mem_MemRead  out  1  MEM-stage control, gated by mem_valid
mem_MemWrite  out  1  MEM-stage control, gated by mem_valid
wb_valid  out  1  WB-stage valid
wb_RegWrite  out  1  WB-stage control, gated by wb_valid
wb_MemToReg  out  1  WB-stage control
wb_wreg  out  REG_W  WB destination register

Behaviour:
- Three registered stages: EX, MEM, WB. Each stage holds a valid bit, the control fields, wreg, and (EX only) rs/rt.
- A bubble is valid=0 with all control fields 0, which is the NOP encoding.
- Reset:
  - Asynchronous; all stages become bubbles.
  - All outputs are 0, including stall, flush and forwardA/B.
  - Reset asserted mid-stream discards all in-flight instructions immediately, without waiting for an edge.
- Advance: each edge, MEM loads EX and WB loads MEM unconditionally (no back-pressure downstream of ID).
- EX load on each edge, in priority order:
  1. flush=1: EX loads a bubble (the ID instruction is squashed).
  2. stall=1: EX loads a bubble (the ID instruction is held upstream and re-presented next cycle).
  3. Otherwise: EX loads the ID bundle, with valid = id_valid; if id_valid=0, control fields are zeroed.
- rt-use: id uses rt when id_ALUSrc=0 or id_MemWrite=1 (R-type, BEQ, SW).
- stall (combinational) = ex_valid & ex_MemRead & (ex_wreg≠0) & id_valid & ((ex_wreg==id_rs) | (rt-use & ex_wreg==id_rt)) & ~flush.
  - Lasts exactly one cycle per load-use pair: after the bubble, the load has moved to MEM and forwarding covers the dependency.
- flush (combinational) = ex_valid & (ex_ALUOp==01) & ex_zero. A not-taken BEQ (ex_zero=0) does not flush.
- forwardA (combinational):
  - 10 if mem_valid & mem_RegWrite & mem_wreg≠0 & mem_wreg==ex_rs;
  - else 01 if wb_valid & wb_RegWrite & wb_wreg≠0 & wb_wreg==ex_rs;
  - else 00.
  - MEM takes priority over WB when both match.
- forwardB: same rule using ex_rt.
- Register 0 is never forwarded and never causes a stall.
- Forwarding selects are 00 whenever ex_valid=0.
- Stage outputs are driven from the stage registers; the gated outputs are 0 when their stage's valid=0.
- Latency: an ID bundle accepted at edge N appears in EX after N, in MEM after N+1, and in WB after N+2.

Test Plan:
- Reset mid-stream: three valid R-types in flight, assert reset between edges -> all valid and control outputs 0 immediately; stall=flush=0.
- Back-to-back R-type: add wreg=3, then add rs=3 -> second instruction in EX gets forwardA=10; with one independent instruction between them -> forwardA=01.
- Load-use: LW wreg=5 in EX, ID R-type rt=5 -> stall=1 for exactly one cycle, EX bubble, then forwardB=01 (load in WB). SW with rt=5 also stalls; addi-style ALUSrc=1 reading rt=5 does not.
- Taken BEQ: BEQ in EX with ex_zero=1 -> flush=1, next EX is a bubble. ex_zero=0 -> flush=0 and ID advances normally.
- Flush vs stall: taken BEQ in EX while ID matches a prior load -> flush=1, stall=0, EX loads bubble.
- $zero: LW wreg=0 followed by R-type rs=0 -> stall=0, forwardA=00; R-type wreg=0 writing back -> forwardA/B stay 00.
